// File: rtl/traffic_pkg.sv
// Shared lamp codes, controller state encoding and lamp-field helpers
// for the multi-approach traffic light controller.
package traffic_pkg;

   localparam logic [2:0] LT_RED    = 3'b100;
   localparam logic [2:0] LT_GREEN  = 3'b010;
   localparam logic [2:0] LT_YELLOW = 3'b001;

   typedef enum logic [1:0] {
      ALL_RED = 2'd0,
      GREEN   = 2'd1,
      YELLOW  = 2'd2
   } state_e;

   // Lowest bit of the 3-bit lamp field belonging to approach idx.
   function automatic int unsigned field_lsb(input int unsigned idx);
      return 3 * idx;
   endfunction

   function automatic logic [2:0] field_code(input state_e st, input logic owner);
      logic [2:0] code;
      code = LT_RED;
      if (owner && (st == GREEN)) begin
         code = LT_GREEN;
      end else if (owner && (st == YELLOW)) begin
         code = LT_YELLOW;
      end
      return code;
   endfunction

   function automatic logic field_is_red(input logic [2:0] code);
      return code == LT_RED;
   endfunction

endpackage

// File: rtl/phase_timer.sv
// Phase timer: counts tick strobes within one controller phase and flags
// the tick on which the programmed terminal count is reached.
module phase_timer
   import traffic_pkg::*;
#(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear_i,
   input  logic             tick_en_i,
   input  logic             hold_i,
   input  logic [CNT_W-1:0] terminal_i,
   output logic [CNT_W-1:0] count_o,
   output logic             done_o
);

   logic [CNT_W-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (clear_i || hold_i) begin
         count_d = '0;
      end else if (tick_en_i) begin
         count_d = count_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;
   assign done_o  = tick_en_i && (count_q == terminal_i);

endmodule

// File: rtl/traffic_light_ctrl.sv
// Multi-approach traffic light controller: rotates green between approaches,
// lets latched pedestrian requests shorten green, and holds all-red on emergency.
module traffic_light_ctrl
   import traffic_pkg::*;
#(
   parameter int NUM_DIR         = 2,
   parameter int GREEN_TICKS     = 6,
   parameter int MIN_GREEN_TICKS = 2,
   parameter int YELLOW_TICKS    = 2,
   parameter int ALLRED_TICKS    = 1,
   parameter int CNT_W           = 8,
   parameter int DIR_W           = (NUM_DIR > 1) ? $clog2(NUM_DIR) : 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 tick_en,
   input  logic [NUM_DIR-1:0]   ped_req,
   input  logic                 emerg,
   output logic [3*NUM_DIR-1:0] light,
   output logic [NUM_DIR-1:0]   ped_walk,
   output logic [DIR_W-1:0]     cur_dir,
   output logic                 hold
);

   if (NUM_DIR < 2) begin : g_chk_num_dir
      $error("traffic_light_ctrl: NUM_DIR must be at least 2");
   end
   if ((GREEN_TICKS < 1) || (YELLOW_TICKS < 1) || (ALLRED_TICKS < 1) || (MIN_GREEN_TICKS < 1)) begin : g_chk_zero
      $error("traffic_light_ctrl: phase durations must be non-zero");
   end
   if (MIN_GREEN_TICKS > GREEN_TICKS) begin : g_chk_min_green
      $error("traffic_light_ctrl: MIN_GREEN_TICKS exceeds GREEN_TICKS");
   end
   if ((GREEN_TICKS >= 2**CNT_W) || (YELLOW_TICKS >= 2**CNT_W) || (ALLRED_TICKS >= 2**CNT_W)) begin : g_chk_cnt_w
      $error("traffic_light_ctrl: a duration does not fit in CNT_W bits");
   end

   localparam logic [DIR_W-1:0] LAST_DIR = DIR_W'(NUM_DIR - 1);
   localparam logic [CNT_W-1:0] T_ALLRED = CNT_W'(ALLRED_TICKS - 1);
   localparam logic [CNT_W-1:0] T_GREEN  = CNT_W'(GREEN_TICKS - 1);
   localparam logic [CNT_W-1:0] T_YELLOW = CNT_W'(YELLOW_TICKS - 1);
   localparam logic [CNT_W-1:0] T_MIN    = CNT_W'(MIN_GREEN_TICKS - 1);

   state_e                 state_q, state_d;
   logic [DIR_W-1:0]       dir_q, dir_d;
   logic [NUM_DIR-1:0]     pending_q, pending_d;
   logic [NUM_DIR-1:0]     walk_q, walk_d;
   logic [3*NUM_DIR-1:0]   light_q, light_d;
   logic                   hold_q, hold_d;
   logic [NUM_DIR-1:0]     dir_onehot;
   logic                   other_pending;
   logic                   tmr_clear, tmr_hold, tmr_done;
   logic [CNT_W-1:0]       tmr_count, tmr_terminal;

   always_comb begin
      tmr_terminal = T_ALLRED;
      case (state_q)
         GREEN:   tmr_terminal = T_GREEN;
         YELLOW:  tmr_terminal = T_YELLOW;
         default: tmr_terminal = T_ALLRED;
      endcase
   end

   // Emergency pins the all-red timer at zero so release always buys a full clearance.
   assign tmr_hold = (state_q == ALL_RED) && emerg;

   phase_timer #(
      .CNT_W(CNT_W)
   ) u_timer (
      .clk        (clk),
      .rst        (rst),
      .clear_i    (tmr_clear),
      .tick_en_i  (tick_en),
      .hold_i     (tmr_hold),
      .terminal_i (tmr_terminal),
      .count_o    (tmr_count),
      .done_o     (tmr_done)
   );

   always_comb begin
      state_d       = state_q;
      dir_d         = dir_q;
      pending_d     = pending_q | ped_req;
      walk_d        = walk_q;
      dir_onehot    = NUM_DIR'(1) << dir_q;
      other_pending = |(pending_q & ~dir_onehot);
      case (state_q)
         ALL_RED: begin
            if (tmr_done && !emerg) begin
               state_d            = GREEN;
               walk_d             = '0;
               walk_d[dir_q]      = pending_d[dir_q];
               pending_d[dir_q]   = 1'b0;
            end
         end
         GREEN: begin
            if (emerg || tmr_done || (tick_en && (tmr_count >= T_MIN) && other_pending)) begin
               state_d = YELLOW;
               walk_d  = '0;
            end
         end
         YELLOW: begin
            if (tmr_done) begin
               state_d = ALL_RED;
               dir_d   = (dir_q == LAST_DIR) ? '0 : dir_q + DIR_W'(1);
            end
         end
         default: begin
            state_d = ALL_RED;
            walk_d  = '0;
         end
      endcase
      tmr_clear = (state_d != state_q);
      hold_d    = (state_d == ALL_RED) && emerg;
   end

   // Lamps are decoded from the next state so they change on the same edge as state.
   always_comb begin
      light_d = '0;
      for (int i = 0; i < NUM_DIR; i++) begin
         light_d[field_lsb(i) +: 3] = field_code(state_d, dir_d == DIR_W'(i));
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ALL_RED;
         dir_q     <= '0;
         pending_q <= '0;
         walk_q    <= '0;
         light_q   <= {NUM_DIR{LT_RED}};
         hold_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         dir_q     <= dir_d;
         pending_q <= pending_d;
         walk_q    <= walk_d;
         light_q   <= light_d;
         hold_q    <= hold_d;
      end
   end

   assign light    = light_q;
   assign ped_walk = walk_q;
   assign cur_dir  = dir_q;
   assign hold     = hold_q;

endmodule

// File: doc/traffic_light_ctrl.md
Name: traffic_light_ctrl

Overview:
Parametrised multi-approach traffic light controller. It is the successor to the fixed 3-state single-signal sequencer. It rotates green between NUM_DIR approaches, with programmable green, yellow and all-red durations counted in tick_en strobes. It adds latched pedestrian requests that shorten the current green, and an emergency all-red hold. It sits between the clock-prescaler strobe and the lamp drivers or pedestrian WALK signals.

Parameters:
NUM_DIR, 2, number of approaches (>=2)
GREEN_TICKS, 6, nominal green length in ticks (>=1)
MIN_GREEN_TICKS, 2, minimum green before a pedestrian request may cut it (1..GREEN_TICKS)
YELLOW_TICKS, 2, yellow length in ticks (>=1)
ALLRED_TICKS, 1, all-red clearance length in ticks (>=1)
CNT_W, 8, phase timer width; all *_TICKS must be < 2**CNT_W
DIR_W, max(1,$clog2(NUM_DIR)), derived width of the direction index

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
tick_en  in  1  one-cycle timing strobe; the timer advances only when it is 1
ped_req  in  NUM_DIR  pedestrian request per approach; any high cycle latches it
emerg  in  1  emergency level; while high, the controller drives and holds all-red
light  out  3*NUM_DIR  per-approach lamp; bits [3i+2:3i] belong to approach i; RED=100, GREEN=010, YELLOW=001
ped_walk  out  NUM_DIR  WALK for approach i; high only while i is green and was served
cur_dir  out  DIR_W  approach currently owning (or next to own) green
hold  out  1  high while in ALL_RED with emerg asserted

Behaviour:
- Reset (async, immediate):
  - state=ALL_RED, timer=0, cur_dir=0, pending=0
  - every light field = RED, ped_walk=0, hold=0
- Outputs are registered and update on the same edge as state, so they are always consistent with state.
- States: ALL_RED, GREEN, YELLOW. Any unused encoding goes to ALL_RED with all lights RED.
- Timer:
  - Cleared on every state entry.
  - Increments on a cycle with tick_en=1 that does not cause an exit.
  - With tick_en=0, neither the timer nor the state changes, except for the emergency GREEN->YELLOW move.
- ALL_RED:
  - All fields RED.
  - Exit when tick_en=1, timer==ALLRED_TICKS-1 and emerg=0 -> GREEN.
  - While emerg=1, the timer is held at 0. On release, a full ALLRED_TICKS elapses before green.
- GREEN:
  - light[cur_dir]=GREEN, all others RED.
  - Exit -> YELLOW on any one of:
    - (a) tick_en=1 and timer==GREEN_TICKS-1
    - (b) tick_en=1, timer>=MIN_GREEN_TICKS-1 and pending[j]=1 for some j!=cur_dir
    - (c) emerg=1, on the next edge, regardless of timer or tick_en
- YELLOW:
  - light[cur_dir]=YELLOW.
  - Exit when tick_en=1 and timer==YELLOW_TICKS-1 -> ALL_RED.
  - On the same edge, cur_dir advances: cur_dir = (cur_dir==NUM_DIR-1) ? 0 : cur_dir+1.
  - Emergency does not cut yellow short.
- Pedestrian requests:
  - pending[i] is set by ped_req[i] on any cycle.
  - On the ALL_RED->GREEN edge for approach i: ped_walk[i] is set to pending[i] and pending[i] is cleared.
  - If ped_req[i] is high on that same edge, it counts as served; pending is not re-set.
  - ped_walk clears on GREEN exit.
  - A request for cur_dir raised during its own green stays pending for the next cycle of the rotation.
- Invariant: at most one field is non-RED at any time. Never GREEN->RED without YELLOW.
- Elaboration check: fail if MIN_GREEN_TICKS>GREEN_TICKS, any duration is 0, or NUM_DIR<2.

Decomposition:
- Package traffic_pkg:
  - light codes RED/GREEN/YELLOW (3-bit)
  - state enum ALL_RED/GREEN/YELLOW
  - light-field pack/unpack function for index i
- One sub-module, phase_timer (CNT_W-bit counter):
  - inputs: clear, tick_en, hold, terminal value
  - output: done = tick_en & (count==terminal)
- Direction rotation, pending register and FSM stay in traffic_light_ctrl.

Test Plan:
1. Defaults, tick_en=1, rst released at cycle 0:
   - ALL_RED at cycle 0
   - dir0 GREEN cycles 1-6 (light=100_010), YELLOW 7-8 (100_001), ALL_RED 9
   - dir1 GREEN 10-15 (010_100)
   - ped_walk stays 0 throughout
2. ped_req[1] one-cycle pulse during dir0 green timer=0:
   - dir0 green lasts exactly 2 cycles, then YELLOW
   - dir1 green has ped_walk=2'b10 for all 6 cycles
   - pending[1] is 0 afterwards
3. emerg raised at dir0 green timer=3, held 10 cycles:
   - next edge YELLOW (2 cycles), then ALL_RED with hold=1 until release
   - 1 more ALL_RED cycle, then dir1 GREEN
4. tick_en every 4th cycle:
   - each phase lasts 4×its ticks in clock cycles
   - light and timer are frozen on non-tick cycles
5. NUM_DIR=3:
   - green order 0,1,2,0
   - cur_dir wraps 2->0 on YELLOW exit
   - light width 9
6. rst asserted mid-YELLOW between clock edges:
   - all fields read 100 before the next clk edge
   - cur_dir=0, pending=0
   - after release, the first green is dir0
